fpu_arbiter: RTL
================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one FPU (div/sqrt, single/double).
REQ-002 Parameter TIMEOUT, default 4095, per-phase cycle limit; 0 disables the timeout.
REQ-003 clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  NREQ  per-requester operation request.
REQ-006 req_ready  out  NREQ  one-hot acceptance; transfer when req_valid[i]&req_ready[i].
REQ-007 req_op  in  2*NREQ  op per requester: 00 single div, 01 single sqrt, 10 double div, 11 double sqrt.
REQ-008 req_a, req_b  in  64*NREQ each  operands; single ops use bits [31:0].
REQ-009 rsp_valid  out  NREQ  one-hot response strobe to the owning requester.
REQ-010 rsp_ready  in  NREQ  response acceptance.
REQ-011 rsp_data  out  64  result; single results zero-extended.
REQ-012 rsp_err  out  1  response is a timeout error.
REQ-013 fpu_process  out  2  op code to FPU; fpu_as/fpu_bs out 32, fpu_ad/fpu_bd out 64 operands.
REQ-014 fpu_a_stb, fpu_b_stb  out  1  operand strobes; fpu_a_ack, fpu_b_ack in 1 acks.
REQ-015 fpu_zs in 32, fpu_zd in 64, fpu_z_stb in 1 result; fpu_z_ack out 1 result ack.
REQ-016 busy  out  1  state != IDLE; grant_id out clog2(NREQ) current owner.

Function
REQ-017 FSM states SHALL be IDLE, SEND_A, SEND_B, WAIT_Z, DRAIN, RESP.
REQ-018 IDLE: req_ready SHALL be asserted combinationally only to the round-robin winner among asserted req_valid, search starting at last_grant+1 mod NREQ.
REQ-019 On acceptance, op and both operands SHALL be latched, last_grant/grant_id updated, next state SEND_A.
REQ-020 fpu_process and operand outputs SHALL hold latched values from SEND_A entry until DRAIN exit.
REQ-021 SEND_A: fpu_a_stb=1 from cycle after acceptance until fpu_a_ack sampled high; then SEND_B for ops 00/10, WAIT_Z for 01/11 (fpu_b_stb never asserted for sqrt).
REQ-022 SEND_B: fpu_b_stb=1 until fpu_b_ack sampled high, then WAIT_Z.
REQ-023 WAIT_Z: on fpu_z_stb=1, capture fpu_zs (op[1]=0) or fpu_zd (op[1]=1), assert fpu_z_ack that same cycle, go DRAIN.
REQ-024 DRAIN: wait until fpu_z_stb=0 (FPU back to idle), then RESP.
REQ-025 RESP: rsp_valid[grant_id]=1, rsp_data/rsp_err stable until rsp_ready[grant_id] high, then IDLE; no new acceptance before IDLE.
REQ-026 Timeout counter (12 bits) SHALL clear on every state entry and count in SEND_A, SEND_B, WAIT_Z; on reaching TIMEOUT (non-zero), go to RESP with rsp_err=1, rsp_data=0, all FPU strobes deasserted.
REQ-027 Simultaneous req_valid with a response pending SHALL wait; a requester may receive rsp and be regranted no earlier than the next IDLE.
REQ-028 req_valid deasserted without acceptance SHALL leave no state change.
REQ-029 Minimum latency acceptance-to-rsp_valid SHALL be FPU latency + 3 cycles.

Reset
REQ-030 On rst all outputs SHALL be 0 (req_ready forced 0 during rst), state IDLE, last_grant=NREQ-1, timeout counter 0.
REQ-031 rst mid-operation SHALL discard the in-flight op with no response; FPU must be reset by the same rst.

Structure
REQ-032 Shared package fpu_arb_pkg SHALL hold op encodings (OP_SDIV, OP_SSQRT, OP_DDIV, OP_DSQRT), state encoding and timeout counter width.
REQ-033 Round-robin selection SHALL be one combinational sub-module fpu_rr_picker (request vector, last grant in; one-hot grant out).

Verification
REQ-034 req0 op 00 a=0x40490FDB b=0x40000000, FPU model z=0x3FC90FDB -> rsp_valid[0], rsp_data=0x000000003FC90FDB, rsp_err=0.
REQ-035 req1 op 01 a=0x40800000 -> fpu_b_stb never high, rsp_valid[1], rsp_data=0x0000000040000000.
REQ-036 req2 op 10 a=0x4024000000000000 b=0x4000000000000000 -> rsp_data=0x4014000000000000 from fpu_zd.
REQ-037 All four req_valid held from reset -> grant order 0,1,2,3,0; rsp_ready[i] low 5 cycles -> rsp_valid held, no new grant.
REQ-038 TIMEOUT=16, model never raises fpu_z_stb -> rsp_err=1, rsp_data=0 exactly 16 cycles after WAIT_Z entry.
REQ-039 rst pulse during WAIT_Z -> all outputs 0 immediately, no rsp_valid; subsequent req3 served first-come with correct result.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// fpu_arb_pkg : op codes, FSM encoding and timeout width for the FPU arbiter
// Revision    : 1.0
// ============================================================================
package fpu_arb_pkg;

  localparam logic [1:0] OP_SDIV  = 2'b00;
  localparam logic [1:0] OP_SSQRT = 2'b01;
  localparam logic [1:0] OP_DDIV  = 2'b10;
  localparam logic [1:0] OP_DSQRT = 2'b11;

  localparam int unsigned TO_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic logic op_is_sqrt(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_double(input logic [1:0] op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_rr_picker.sv
`default_nettype none
// ============================================================================
// fpu_rr_picker : combinational round-robin picker, search starts at last+1
// Revision      : 1.0
// ============================================================================
module fpu_rr_picker
  import fpu_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] grant_o
);

  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(last_i) + 1 + k) % NREQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_arbiter : round-robin sharing of one div/sqrt FPU among NREQ requesters
// Revision    : 1.0
// ============================================================================
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 4095,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [2*NREQ-1:0]    req_op_i,
  input  logic [64*NREQ-1:0]   req_a_i,
  input  logic [64*NREQ-1:0]   req_b_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [63:0]          rsp_data_o,
  output logic                 rsp_err_o,
  output logic [1:0]           fpu_process_o,
  output logic [31:0]          fpu_as_o,
  output logic [31:0]          fpu_bs_o,
  output logic [63:0]          fpu_ad_o,
  output logic [63:0]          fpu_bd_o,
  output logic                 fpu_a_stb_o,
  output logic                 fpu_b_stb_o,
  input  logic                 fpu_a_ack_i,
  input  logic                 fpu_b_ack_i,
  input  logic [31:0]          fpu_zs_i,
  input  logic [63:0]          fpu_zd_i,
  input  logic                 fpu_z_stb_i,
  output logic                 fpu_z_ack_o,
  output logic                 busy_o,
  output logic [IDW-1:0]       grant_id_o
);

  localparam logic [TO_W-1:0] TO_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [63:0]     a_q, a_d, b_q, b_d, data_q, data_d;
  logic            err_q, err_d;
  logic [IDW-1:0]  last_q, last_d, gid_q, gid_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;

  logic [NREQ-1:0] grant_w;
  logic [IDW-1:0]  win_w;
  logic            counting_w, fpu_own_w, tmo_w;

  fpu_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (grant_w)
  );

  always_comb begin
    win_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_w[i]) win_w = IDW'(i);
    end
  end

  assign counting_w = (state_q == ST_SEND_A) || (state_q == ST_SEND_B) || (state_q == ST_WAIT_Z);
  assign fpu_own_w  = counting_w || (state_q == ST_DRAIN);
  assign tmo_w      = (TIMEOUT != 0) && counting_w && (tcnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    last_d  = last_q;
    gid_d   = gid_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant_w) begin
          op_d    = req_op_i[{win_w, 1'b0} +: 2];
          a_d     = req_a_i[{win_w, 6'd0} +: 64];
          b_d     = req_b_i[{win_w, 6'd0} +: 64];
          last_d  = win_w;
          gid_d   = win_w;
          err_d   = 1'b0;
          data_d  = '0;
          state_d = ST_SEND_A;
        end
      end
      ST_SEND_A: if (fpu_a_ack_i) state_d = op_is_sqrt(op_q) ? ST_WAIT_Z : ST_SEND_B;
      ST_SEND_B: if (fpu_b_ack_i) state_d = ST_WAIT_Z;
      ST_WAIT_Z: begin
        if (fpu_z_stb_i) begin
          data_d  = op_is_double(op_q) ? fpu_zd_i : {32'h0, fpu_zs_i};
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (!fpu_z_stb_i) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready_i[gid_q]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // An FPU handshake landing on the expiry cycle wins over the timeout
    if (tmo_w && (state_d == state_q)) begin
      state_d = ST_RESP;
      err_d   = 1'b1;
      data_d  = '0;
    end
    tcnt_d = ((state_d != state_q) || !counting_w) ? '0 : tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= LAST_RST;
      gid_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign req_ready_o   = ((state_q == ST_IDLE) && !rst) ? grant_w : '0;
  assign fpu_process_o = fpu_own_w ? op_q : 2'b00;
  assign fpu_as_o      = fpu_own_w ? a_q[31:0] : '0;
  assign fpu_bs_o      = fpu_own_w ? b_q[31:0] : '0;
  assign fpu_ad_o      = fpu_own_w ? a_q : '0;
  assign fpu_bd_o      = fpu_own_w ? b_q : '0;
  assign fpu_a_stb_o   = (state_q == ST_SEND_A);
  assign fpu_b_stb_o   = (state_q == ST_SEND_B);
  assign fpu_z_ack_o   = (state_q == ST_WAIT_Z) && fpu_z_stb_i;
  assign rsp_valid_o   = (state_q == ST_RESP) ? (NREQ'(1) << gid_q) : '0;
  assign rsp_data_o    = (state_q == ST_RESP) ? data_q : '0;
  assign rsp_err_o     = (state_q == ST_RESP) && err_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign grant_id_o    = gid_q;

endmodule
`default_nettype wire
